gpr_wb_arbiter: RTL and testbench

GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

---
 rtl/gpr_wb_if.sv | 27 ++
 rtl/gpr_wb_arbiter.sv | 87 ++++++++
 tb/tb_gpr_wb_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_wb_if.sv
// Write-back bus between the execution units (ALU, MEM, MDU) and the GPR write-back arbiter.
// The master side drives requests; the slave side returns grants and the registered write port.
interface gpr_wb_if #(
    parameter int DW = 32
);
    logic [2:0]      req;
    logic [14:0]     req_rw;
    logic [3*DW-1:0] req_wd;
    logic [2:0]      req_ovf;
    logic [2:0]      gnt;
    logic            GPRWr;
    logic [4:0]      rw;
    logic [DW-1:0]   wd;
    logic            overflow;
    logic            overflag;
    logic [7:0]      ovf_cnt;

    modport master (
        output req, req_rw, req_wd, req_ovf,
        input  gnt, GPRWr, rw, wd, overflow, overflag, ovf_cnt
    );

    modport slave (
        input  req, req_rw, req_wd, req_ovf,
        output gnt, GPRWr, rw, wd, overflow, overflag, ovf_cnt
    );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// Three-way GPR write-back arbiter with a registered register-file write port and overflow tracking.
// Define WB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority MEM > ALU > MDU.
module gpr_wb_arbiter #(
    parameter int DW = 32
) (
    input  logic       clk,
    input  logic       rst,
    gpr_wb_if.slave    bus
);
    localparam int NREQ = 3;

    logic [NREQ-1:0] gnt_c;
    logic [4:0]      sel_rw;
    logic [DW-1:0]   sel_wd;
    logic            sel_ovf;

`ifdef WB_ROUND_ROBIN_EN
    logic [1:0] ptr;

    // Search starts at ptr and wraps 2 -> 0.
    always_comb begin
        gnt_c = '0;
        case (ptr)
            2'd1:    gnt_c = bus.req[1] ? 3'b010 : bus.req[2] ? 3'b100 : bus.req[0] ? 3'b001 : 3'b000;
            2'd2:    gnt_c = bus.req[2] ? 3'b100 : bus.req[0] ? 3'b001 : bus.req[1] ? 3'b010 : 3'b000;
            default: gnt_c = bus.req[0] ? 3'b001 : bus.req[1] ? 3'b010 : bus.req[2] ? 3'b100 : 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 2'd0;
        end else if (|bus.gnt) begin
            ptr <= bus.gnt[0] ? 2'd1 : bus.gnt[1] ? 2'd2 : 2'd0;
        end
    end
`else
    always_comb begin
        gnt_c = '0;
        if (bus.req[1])      gnt_c = 3'b010;
        else if (bus.req[0]) gnt_c = 3'b001;
        else if (bus.req[2]) gnt_c = 3'b100;
    end
`endif

    // Masking here also discards any grant in a reset cycle, so the output stage needs no extra qualifier.
    assign bus.gnt = rst ? '0 : gnt_c;

    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        sel_rw  = '0;
        sel_wd  = '0;
        sel_ovf = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.gnt[i]) begin
                sel_rw  = bus.req_rw[5*i +: 5];
                sel_wd  = bus.req_wd[DW*i +: DW];
                sel_ovf = bus.req_ovf[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.GPRWr    <= 1'b0;
            bus.rw       <= '0;
            bus.wd       <= '0;
            bus.overflow <= 1'b0;
            bus.overflag <= 1'b0;
            bus.ovf_cnt  <= '0;
        end else if (|bus.gnt) begin
            bus.GPRWr    <= (sel_rw != 5'd0) && !sel_ovf;
            bus.rw       <= sel_rw;
            bus.wd       <= sel_wd;
            bus.overflow <= sel_ovf;
            if (sel_ovf) begin
                bus.overflag <= 1'b1;
                if (bus.ovf_cnt != 8'hFF) bus.ovf_cnt <= bus.ovf_cnt + 8'd1;
            end
        end else begin
            // rw/wd deliberately hold their last values in idle cycles.
            bus.GPRWr    <= 1'b0;
            bus.overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: directed scenarios plus randomized traffic against a reference model.
// Honours WB_ROUND_ROBIN_EN the same way as the design.
module tb_gpr_wb_arbiter;
    localparam int DW = 32;

    logic clk;
    logic rst;

    gpr_wb_if #(.DW(DW)) bus ();

    gpr_wb_arbiter #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    int          m_ptr;
    logic        m_wr;
    logic [4:0]  m_rw;
    logic [DW-1:0] m_wd;
    logic        m_ovf;
    logic        m_flag;
    int          m_cnt;
    logic [2:0]  last_gnt;
    logic [2:0]  pend;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Priority order from the arbitration rules, not from any encoding of the design.
    function automatic logic [2:0] model_gnt(input logic [2:0] r, input int p);
        int order[3];
        for (int k = 0; k < 3; k++) begin
`ifdef WB_ROUND_ROBIN_EN
            order[k] = (p + k) % 3;
`else
            order[k] = (k == 0) ? 1 : (k == 1) ? 0 : 2;
`endif
        end
        for (int k = 0; k < 3; k++)
            if (r[order[k]]) return 3'(1 << order[k]);
        return 3'b000;
    endfunction

    task automatic model_edge(input logic [2:0] g);
        int i;
        if (rst) begin
            m_ptr = 0; m_wr = 0; m_rw = 0; m_wd = 0; m_ovf = 0; m_flag = 0; m_cnt = 0;
        end else if (g != 3'b000) begin
            i = g[0] ? 0 : g[1] ? 1 : 2;
            m_rw  = bus.req_rw[5*i +: 5];
            m_wd  = bus.req_wd[DW*i +: DW];
            m_ovf = bus.req_ovf[i];
            m_wr  = (m_rw != 0) && !m_ovf;
            if (m_ovf) begin
                m_flag = 1;
                m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
            end
`ifdef WB_ROUND_ROBIN_EN
            m_ptr = (i + 1) % 3;
`endif
        end else begin
            m_wr = 0;
            m_ovf = 0;
        end
    endtask

    // One clock: gnt checked mid-cycle, registered outputs checked just after the edge.
    task automatic cycle();
        logic [2:0] eg;
        @(negedge clk);
        eg = rst ? 3'b000 : model_gnt(bus.req, m_ptr);
        check("gnt", 64'(bus.gnt), 64'(eg));
        last_gnt = bus.gnt;
        @(posedge clk);
        model_edge(eg);
        #1;
        check("GPRWr",    64'(bus.GPRWr),    64'(m_wr));
        check("rw",       64'(bus.rw),       64'(m_rw));
        check("wd",       64'(bus.wd),       64'(m_wd));
        check("overflow", 64'(bus.overflow), 64'(m_ovf));
        check("overflag", 64'(bus.overflag), 64'(m_flag));
        check("ovf_cnt",  64'(bus.ovf_cnt),  64'(m_cnt));
    endtask

    task automatic set_req(input int i, input logic on, input logic [4:0] rw_v,
                           input logic [DW-1:0] wd_v, input logic ovf_v);
        bus.req[i]             = on;
        bus.req_rw[5*i +: 5]   = rw_v;
        bus.req_wd[DW*i +: DW] = wd_v;
        bus.req_ovf[i]         = ovf_v;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 5'd0, '0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    logic [2:0] exp_seq [6];

    initial begin
        m_ptr = 0; m_wr = 0; m_rw = 0; m_wd = 0; m_ovf = 0; m_flag = 0; m_cnt = 0;
        pend = '0;
        rst = 1'b1;
        idle_all();
        @(posedge clk);
        #1;

        // Reset state.
        do_reset();
        check("rst_GPRWr", 64'(bus.GPRWr), 64'(0));
        check("rst_ovf_cnt", 64'(bus.ovf_cnt), 64'(0));
        cycle();
        check("idle_gnt", 64'(last_gnt), 64'(0));

        // Single ALU write.
        set_req(0, 1'b1, 5'd8, 32'hDEADBEEF, 1'b0);
        cycle();
        check("single_gnt", 64'(last_gnt), 64'(3'b001));
        check("single_GPRWr", 64'(bus.GPRWr), 64'(1));
        check("single_rw", 64'(bus.rw), 64'(8));
        check("single_wd", 64'(bus.wd), 64'(32'hDEADBEEF));
        idle_all();
        cycle();
        check("idle_GPRWr", 64'(bus.GPRWr), 64'(0));
        check("idle_wd_hold", 64'(bus.wd), 64'(32'hDEADBEEF));

        // Write to r0 is consumed silently.
        set_req(1, 1'b1, 5'd0, 32'h1, 1'b0);
        cycle();
        check("r0_gnt", 64'(last_gnt), 64'(3'b010));
        check("r0_GPRWr", 64'(bus.GPRWr), 64'(0));
        check("r0_overflag", 64'(bus.overflag), 64'(0));
        idle_all();

        // All requesters held high for six cycles from ptr=0.
        do_reset();
`ifdef WB_ROUND_ROBIN_EN
        exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
        exp_seq = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
`endif
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 5'(10 + i), DW'(32'hA000 + i), 1'b0);
        for (int c = 0; c < 6; c++) begin
            cycle();
            check($sformatf("all_gnt%0d", c), 64'(last_gnt), 64'(exp_seq[c]));
        end
        idle_all();
        cycle();

        // Randomized traffic: each requester holds its fields until granted.
        for (int c = 0; c < 250; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (last_gnt[i]) begin
                    pend[i] = 1'b0;
                    set_req(i, 1'b0, 5'd0, '0, 1'b0);
                end
                if (!pend[i] && $urandom_range(0, 99) < 55) begin
                    pend[i] = 1'b1;
                    set_req(i, 1'b1,
                            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                            DW'($urandom),
                            ($urandom_range(0, 7) == 0));
                end
            end
            cycle();
        end
        pend = '0;

        // Reset asserted during traffic.
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 5'(20 + i), DW'(32'hB000 + i), 1'b1);
        rst = 1'b1;
        cycle();
        check("rst_traffic_gnt", 64'(last_gnt), 64'(0));
        check("rst_traffic_GPRWr", 64'(bus.GPRWr), 64'(0));
        check("rst_traffic_rw", 64'(bus.rw), 64'(0));
        check("rst_traffic_wd", 64'(bus.wd), 64'(0));
        check("rst_traffic_overflag", 64'(bus.overflag), 64'(0));
        check("rst_traffic_cnt", 64'(bus.ovf_cnt), 64'(0));
        rst = 1'b0;
        cycle();
`ifdef WB_ROUND_ROBIN_EN
        check("post_rst_gnt", 64'(last_gnt), 64'(3'b001));
`else
        check("post_rst_gnt", 64'(last_gnt), 64'(3'b010));
`endif
        idle_all();

        // Overflow handling and counter saturation.
        do_reset();
        set_req(2, 1'b1, 5'd3, 32'h55, 1'b1);
        cycle();
        check("ovf_gnt", 64'(last_gnt), 64'(3'b100));
        check("ovf_GPRWr", 64'(bus.GPRWr), 64'(0));
        check("ovf_overflow", 64'(bus.overflow), 64'(1));
        check("ovf_overflag", 64'(bus.overflag), 64'(1));
        check("ovf_cnt1", 64'(bus.ovf_cnt), 64'(1));
        for (int c = 0; c < 300; c++) cycle();
        check("ovf_cnt_sat", 64'(bus.ovf_cnt), 64'(255));
        idle_all();
        cycle();
        check("ovf_idle_overflow", 64'(bus.overflow), 64'(0));
        check("ovf_sticky", 64'(bus.overflag), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
